uvmt_cv32e40s_achk_checker: RTL
===============================

UVMT_CV32E40S_ACHK_CHECKER -- requirements
Module: uvmt_cv32e40s_achk_checker

Interface
REQ-001 The block SHALL have parameter MAX_OUTSTANDING, default 2, the maximum number of accepted but unanswered OBI transactions (range 1..8).
REQ-002 The block SHALL have parameter CHECK_STABLE, default 1, which enables the address-phase stability check.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; ports SHALL be clk (input, 1, clock) and rst (input, 1, reset).
REQ-004 The block SHALL have these inputs:
- req_i, 1, OBI request.
- gnt_i, 1, OBI grant.
- addr_i, 32, address.
- we_i, 1, write enable.
- be_i, 4, byte enables.
- prot_i, 3, protection.
- memtype_i, 2, memory type.
- dbg_i, 1, debug-mode access.
- wdata_i, 32, write data.
- achk_i, 12, address-phase checksum driven by the core.
- integrity_i, 1, the addressed region has integrity.
- rvalid_i, 1, OBI response valid.
REQ-005 The block SHALL have these outputs:
- achk_err_o, 1, registered mismatch flag for an accepted request.
- resp_achk_err_o, 1, mismatch flag aligned with the matching response.
- stable_err_o, 1, address phase changed while waiting for grant.
- overflow_o, 1, sticky, too many outstanding transactions.
- underflow_o, 1, sticky, response with none outstanding.
- outstanding_o, $clog2(MAX_OUTSTANDING+1), current outstanding count.

Function
REQ-006 The expected checksum SHALL be formed bit by bit as follows:
- [0] = ^addr[7:0], [1] = ^addr[15:8], [2] = ^addr[23:16], [3] = ^addr[31:24].
- [4] = ~^{prot, memtype}.
- [5] = ~^{be, we}.
- [6] = ~^dbg.
- [7] = ~^atop, with atop tied to 0, so bit 7 = 1.
- [8..11] = ^wdata byte 0..3.
REQ-007 A request SHALL be accepted in a cycle where req_i && gnt_i.
REQ-008 mismatch SHALL be defined as integrity_i && (achk_i != expected); the block SHALL evaluate it in the accept cycle only.
REQ-009 achk_err_o SHALL be high exactly one cycle after an accept whose mismatch is 1, and low otherwise.
REQ-010 On each accept, the block SHALL push the mismatch bit into an in-order FIFO of depth MAX_OUTSTANDING.
REQ-011 On each rvalid_i with count > 0, the block SHALL pop the FIFO head; resp_achk_err_o SHALL equal the popped bit combinationally in that same rvalid_i cycle, and be 0 when rvalid_i is low.
REQ-012 Accept and rvalid_i in the same cycle with count > 0 SHALL pop the head and push the tail; the count SHALL be unchanged.
REQ-013 rvalid_i with count == 0 SHALL set underflow_o, drive resp_achk_err_o low and leave the count at 0; this holds even when an accept occurs in the same cycle, because a response can never answer a same-cycle request.
REQ-014 When count == 0 and an accept and rvalid_i coincide, the push SHALL still occur and the count SHALL become 1.
REQ-015 An accept with count == MAX_OUTSTANDING and no valid pop SHALL set overflow_o, discard the push and leave the count saturated.
REQ-016 Count arithmetic SHALL never wrap in either direction.
REQ-017 When CHECK_STABLE == 1, stable_err_o SHALL pulse one cycle after any cycle in which:
- req_i was high and gnt_i was low in the previous cycle, and
- in the current cycle req_i is low, or any of addr/we/be/prot/memtype/dbg/wdata/achk differs from the previous cycle.
REQ-018 When CHECK_STABLE == 0, stable_err_o SHALL be tied to 0.
REQ-019 overflow_o and underflow_o SHALL remain set until reset.

Reset
REQ-020 While rst is high at a clk edge, the block SHALL:
- clear all outputs to 0,
- set the count to 0,
- invalidate the FIFO contents,
- clear the registered address-phase snapshot and its pending flag.
REQ-021 A reset asserted mid-transaction SHALL discard all outstanding entries; a response arriving after reset is released SHALL then flag underflow_o.

Structure
REQ-022 The checksum function and the OBI address-phase struct (addr/we/be/prot/memtype/dbg/wdata) SHALL reside in a shared package, reusable by the response-side checksum logic.
REQ-023 The in-order FIFO SHALL be a separate sub-module, uvmt_cv32e40s_achk_fifo, parameterized by depth and width and exposing full/empty.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Good read: addr 0x00000100, we 0, be 0xF, prot 3'b111, memtype 0, dbg 0, wdata 0, achk 0x0E2, integrity 1 -> achk_err_o 0; resp_achk_err_o 0 on rvalid_i.
- Corrupt bit: same request with achk 0x0E3 -> achk_err_o 1 the next cycle; resp_achk_err_o 1 on the matching rvalid_i.
- No integrity: achk 0x0E3, integrity 0 -> no errors reported.
- Ordering, MAX_OUTSTANDING 2: accept good then bad, then two rvalid_i -> resp_achk_err_o 0 then 1; a third accept before any response -> overflow_o 1.
- Boundary: rvalid_i with outstanding_o 0 -> underflow_o 1; simultaneous accept and rvalid_i at count 1 -> outstanding_o stays 1.
- Stability: req_i held with gnt_i 0 and addr changed 0x100 -> 0x104 -> stable_err_o 1 for one cycle; rst pulsed with 2 outstanding -> outstanding_o 0.

Source files
------------

// File: rtl/uvmt_cv32e40s_achk_pkg.sv
// Shared OBI address-phase definitions and the address-phase checksum.
// The response-side checksum logic reuses the same function.
package uvmt_cv32e40s_achk_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [2:0]  prot;
    logic [1:0]  memtype;
    logic        dbg;
    logic [31:0] wdata;
  } obi_aphase_t;

  localparam int ACHK_W = 12;

  // atop is not carried on this interface, so its inverted parity is always 1
  function automatic logic [ACHK_W-1:0] achk_calc(input obi_aphase_t a);
    logic [ACHK_W-1:0] c;
    c[0]  = ^a.addr[7:0];
    c[1]  = ^a.addr[15:8];
    c[2]  = ^a.addr[23:16];
    c[3]  = ^a.addr[31:24];
    c[4]  = ~^{a.prot, a.memtype};
    c[5]  = ~^{a.be, a.we};
    c[6]  = ~a.dbg;
    c[7]  = 1'b1;
    c[8]  = ^a.wdata[7:0];
    c[9]  = ^a.wdata[15:8];
    c[10] = ^a.wdata[23:16];
    c[11] = ^a.wdata[31:24];
    return c;
  endfunction

endpackage

// File: rtl/uvmt_cv32e40s_achk_fifo.sv
// In-order FIFO with non-wrapping occupancy count.
// Pushes into a full FIFO are dropped unless a pop frees a slot in the same cycle.
module uvmt_cv32e40s_achk_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uvmt_cv32e40s_achk_checker.sv
// OBI address-phase checksum checker: flags achk mismatches at accept and
// again on the matching response, plus address-phase stability and count faults.
module uvmt_cv32e40s_achk_checker
  import uvmt_cv32e40s_achk_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CHECK_STABLE    = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   req_i,
  input  logic                                   gnt_i,
  input  logic [31:0]                            addr_i,
  input  logic                                   we_i,
  input  logic [3:0]                             be_i,
  input  logic [2:0]                             prot_i,
  input  logic [1:0]                             memtype_i,
  input  logic                                   dbg_i,
  input  logic [31:0]                            wdata_i,
  input  logic [11:0]                            achk_i,
  input  logic                                   integrity_i,
  input  logic                                   rvalid_i,
  output logic                                   achk_err_o,
  output logic                                   resp_achk_err_o,
  output logic                                   stable_err_o,
  output logic                                   overflow_o,
  output logic                                   underflow_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

  obi_aphase_t aphase;
  logic        accept;
  logic        mismatch;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_rdata;
  logic        pop;
  logic        achk_err_p1;
  logic        overflow_p1;
  logic        underflow_p1;

  assign aphase = '{addr: addr_i, we: we_i, be: be_i, prot: prot_i,
                    memtype: memtype_i, dbg: dbg_i, wdata: wdata_i};

  assign accept   = req_i && gnt_i;
  assign mismatch = integrity_i && (achk_i != achk_calc(aphase));
  // An empty FIFO means the response cannot belong to a same-cycle request
  assign pop      = rvalid_i && !fifo_empty;

  uvmt_cv32e40s_achk_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .wdata (mismatch),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding_o)
  );

  assign resp_achk_err_o = pop && fifo_rdata;

  // Stage p1: accept-time flag and sticky count faults
  always_ff @(posedge clk) begin
    if (rst) begin
      achk_err_p1  <= 1'b0;
      overflow_p1  <= 1'b0;
      underflow_p1 <= 1'b0;
    end else begin
      achk_err_p1 <= accept && mismatch;
      if (accept && fifo_full && !pop) overflow_p1  <= 1'b1;
      if (rvalid_i && fifo_empty)      underflow_p1 <= 1'b1;
    end
  end

  assign achk_err_o  = achk_err_p1;
  assign overflow_o  = overflow_p1;
  assign underflow_o = underflow_p1;

  generate
    if (CHECK_STABLE != 0) begin : g_stable
      obi_aphase_t snap_p0;
      logic [11:0] snap_achk_p0;
      logic        pending_p0;
      logic        stable_err_p1;
      logic        changed;

      assign changed = !req_i || (aphase != snap_p0) || (achk_i != snap_achk_p0);

      // Stage p0: snapshot of a stalled address phase; p1: stability flag
      always_ff @(posedge clk) begin
        if (rst) begin
          snap_p0       <= '0;
          snap_achk_p0  <= '0;
          pending_p0    <= 1'b0;
          stable_err_p1 <= 1'b0;
        end else begin
          snap_p0       <= aphase;
          snap_achk_p0  <= achk_i;
          pending_p0    <= req_i && !gnt_i;
          stable_err_p1 <= pending_p0 && changed;
        end
      end

      assign stable_err_o = stable_err_p1;
    end else begin : g_no_stable
      assign stable_err_o = 1'b0;
    end
  endgenerate

endmodule
